// File: rtl/s2p_rx_pkg.sv
// Shared types and defaults for the s2p_rx serial-to-parallel receiver.
// The p2s serializer takes its word width from the same default.
package s2p_rx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_TIMEOUT = 8;

  // Idle counter width; a disabled timeout still needs a 1-bit register.
  function automatic int idle_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/s2p_rx_idle_timer.sv
// Clearable saturating idle counter. tc fires on the increment that
// makes the count reach LIMIT; LIMIT=0 never fires.
module s2p_idle_timer
  import s2p_rx_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int IW = idle_width(LIMIT);
  localparam logic [IW-1:0] MAX_VAL = '1;

  logic [IW-1:0] count_reg;
  logic [IW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr)
      count_next = '0;
    else if (inc && (count_reg != MAX_VAL))
      count_next = count_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

  generate
    if (LIMIT == 0) begin : g_disabled
      assign tc = 1'b0;
    end else begin : g_enabled
      localparam logic [IW-1:0] TC_VAL = IW'(LIMIT - 1);
      assign tc = inc && !clr && (count_reg == TC_VAL);
    end
  endgenerate

endmodule

// File: rtl/s2p_rx.sv
// Serial-to-parallel receiver: assembles WIDTH valid bits (MSB first) into
// a word, tolerating vld gaps, with timeout and synchronous abort.
module s2p_rx
  import s2p_rx_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             data,
  input  logic             vld,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  // Only WIDTH-1 bits need holding; the last bit goes straight to dout.
  logic [WIDTH-2:0] shift_reg, shift_next;
  logic [WIDTH-1:0] dout_reg, dout_next;
  logic             dout_vld_reg, dout_vld_next;
  logic             err_reg, err_next;
  logic [WIDTH-1:0] captured;
  logic             timer_clr, timer_inc, timer_tc;

  assign captured = {shift_reg, data};

  s2p_idle_timer #(
    .LIMIT (TIMEOUT)
  ) u_idle_timer (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (timer_clr),
    .inc   (timer_inc),
    .tc    (timer_tc)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    shift_next    = shift_reg;
    dout_next     = dout_reg;
    dout_vld_next = 1'b0;
    err_next      = 1'b0;
    timer_clr     = 1'b0;
    timer_inc     = 1'b0;

    if (clr) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      timer_clr  = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          timer_clr = 1'b1;
          if (vld) begin
            shift_next = captured[WIDTH-2:0];
            cnt_next   = CW'(1);
            state_next = ST_RECV;
          end
        end
        ST_RECV: begin
          if (vld) begin
            timer_clr = 1'b1;
            if (cnt_reg == LAST_BIT) begin
              dout_next     = captured;
              dout_vld_next = 1'b1;
              cnt_next      = '0;
              state_next    = ST_IDLE;
            end else begin
              shift_next = captured[WIDTH-2:0];
              cnt_next   = cnt_reg + 1'b1;
            end
          end else begin
            timer_inc = 1'b1;
            if (timer_tc) begin
              err_next   = 1'b1;
              cnt_next   = '0;
              state_next = ST_IDLE;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      shift_reg    <= '0;
      dout_reg     <= '0;
      dout_vld_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      shift_reg    <= shift_next;
      dout_reg     <= dout_next;
      dout_vld_reg <= dout_vld_next;
      err_reg      <= err_next;
    end
  end

  assign dout     = dout_reg;
  assign dout_vld = dout_vld_reg;
  assign busy     = (state_reg == ST_RECV);
  assign err      = err_reg;

endmodule

// File: tb/tb_s2p_rx.sv
// Directed and randomized bench for s2p_rx against a bit-queue reference
// model; the p2s upstream is emulated by driving data/vld directly.
module tb_s2p_rx;

  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             data = 1'b0;
  logic             vld = 1'b0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             busy;
  logic             err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int               bits_q[$];
  int               idle_cnt = 0;
  logic [WIDTH-1:0] exp_dout = '0;
  logic             exp_vld = 1'b0;
  logic             exp_err = 1'b0;
  logic             exp_busy = 1'b0;

  s2p_rx #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .data     (data),
    .vld      (vld),
    .clr      (clr),
    .dout     (dout),
    .dout_vld (dout_vld),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check_outputs(input string tag);
    checks++;
    assert (dout === exp_dout) else begin
      errors++;
      $error("FAIL %s dout: got %b expected %b", tag, dout, exp_dout);
    end
    checks++;
    assert (dout_vld === exp_vld) else begin
      errors++;
      $error("FAIL %s dout_vld: got %b expected %b", tag, dout_vld, exp_vld);
    end
    checks++;
    assert (busy === exp_busy) else begin
      errors++;
      $error("FAIL %s busy: got %b expected %b", tag, busy, exp_busy);
    end
    checks++;
    assert (err === exp_err) else begin
      errors++;
      $error("FAIL %s err: got %b expected %b", tag, err, exp_err);
    end
  endtask

  task automatic model_reset();
    bits_q.delete();
    idle_cnt = 0;
    exp_dout = '0;
    exp_vld  = 1'b0;
    exp_err  = 1'b0;
    exp_busy = 1'b0;
  endtask

  // Word-level behaviour: a partial word is a list of received bits.
  task automatic model_clock(input logic v, input logic d, input logic c);
    logic [WIDTH-1:0] w;
    exp_vld = 1'b0;
    exp_err = 1'b0;
    if (c) begin
      bits_q.delete();
      idle_cnt = 0;
    end else if (v) begin
      bits_q.push_back(int'(d));
      idle_cnt = 0;
      if (bits_q.size() == WIDTH) begin
        w = '0;
        foreach (bits_q[i]) w = {w[WIDTH-2:0], bits_q[i][0]};
        exp_dout = w;
        exp_vld  = 1'b1;
        bits_q.delete();
      end
    end else if (bits_q.size() > 0) begin
      idle_cnt++;
      if (TIMEOUT != 0 && idle_cnt >= TIMEOUT) begin
        exp_err = 1'b1;
        bits_q.delete();
        idle_cnt = 0;
      end
    end
    exp_busy = (bits_q.size() > 0);
  endtask

  task automatic step(input logic v, input logic d, input logic c, input string tag);
    vld  = v;
    data = d;
    clr  = c;
    @(posedge clk);
    model_clock(v, d, c);
    #1;
    check_outputs(tag);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int gap, input string tag);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      step(1'b1, w[i], 1'b0, tag);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, tag);
    end
  endtask

  initial begin
    int pv;
    #1;
    check_outputs("reset");
    #8;
    n_rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, "idle");

    // 1: back-to-back bits
    send_word(4'b1001, 0, "t1");
    step(1'b0, 1'b0, 1'b0, "t1_after");
    $display("t1 word 1001 dout=%b", dout);

    // 2: one-cycle gaps between bits
    send_word(4'b1100, 1, "t2");
    $display("t2 word 1100 dout=%b", dout);

    // 3: timeout after two bits, then a fresh word
    step(1'b1, 1'b1, 1'b0, "t3_b");
    step(1'b1, 1'b0, 1'b0, "t3_b");
    for (int i = 0; i < TIMEOUT + 1; i++) step(1'b0, 1'b0, 1'b0, "t3_idle");
    send_word(4'b0110, 0, "t3_word");
    $display("t3 timeout then word 0110 dout=%b", dout);

    // 4: clr after three bits
    step(1'b1, 1'b1, 1'b0, "t4_b");
    step(1'b1, 1'b0, 1'b0, "t4_b");
    step(1'b1, 1'b1, 1'b0, "t4_b");
    step(1'b0, 1'b0, 1'b1, "t4_clr");
    step(1'b0, 1'b0, 1'b1, "t4_clr_idle");
    send_word(4'b0011, 0, "t4_word");
    $display("t4 clr then word 0011 dout=%b", dout);

    // 5: two words with no bubble
    send_word(4'b1001, 0, "t5_w0");
    send_word(4'b0110, 0, "t5_w1");
    step(1'b0, 1'b0, 1'b0, "t5_after");
    $display("t5 back-to-back dout=%b", dout);

    // 6: async reset mid-word, then word, then vld+clr collision
    step(1'b1, 1'b1, 1'b0, "t6_b");
    step(1'b1, 1'b1, 1'b0, "t6_b");
    vld = 1'b0;
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    check_outputs("t6_async_rst");
    #2;
    n_rst = 1'b1;
    send_word(4'b1111, 0, "t6_word");
    step(1'b1, 1'b0, 1'b0, "t6_b");
    step(1'b1, 1'b1, 1'b1, "t6_vld_clr");
    send_word(4'b1010, 0, "t6_after_clr");
    $display("t6 reset/clr dout=%b", dout);

    // Randomized traffic with phases of varying vld density
    for (int ph = 0; ph < 12; ph++) begin
      pv = (ph % 3 == 0) ? 15 : ((ph % 3 == 1) ? 60 : 95);
      for (int i = 0; i < 60; i++) begin
        step(($urandom_range(0, 99) < pv), 1'($urandom), ($urandom_range(0, 99) < 3), "rand");
      end
      $display("random phase %0d vld%%=%0d dout=%b", ph, pv, dout);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
